// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - merges pipeline WB and long-latency register writes onto one regfile port
module reg_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en,
  input  logic [ADDR_WIDTH-1:0]      wb_addr,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  output logic                       wb_stall,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [ADDR_WIDTH-1:0]      lu_addr,
  input  logic [DATA_WIDTH-1:0]      lu_data,
  output logic                       reg_write_en,
  output logic [ADDR_WIDTH-1:0]      reg_write_addr,
  output logic [DATA_WIDTH-1:0]      reg_write_data,
  input  logic [ADDR_WIDTH-1:0]      q_addr_1,
  input  logic [ADDR_WIDTH-1:0]      q_addr_2,
  output logic                       q_hit_1,
  output logic                       q_hit_2,
  output logic [DATA_WIDTH-1:0]      q_data_1,
  output logic [DATA_WIDTH-1:0]      q_data_2,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];

  // Pointers carry one extra wrap bit so full and empty differ.
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             full;
  logic             empty;
  logic             ready_q;
  logic [SC_W-1:0]  starve_cnt;

  logic push;
  logic force_fifo;
  logic wb_win;
  logic fifo_win;

  assign count   = wr_ptr - rd_ptr;
  assign wr_idx  = wr_ptr[PTR_W-1:0];
  assign rd_idx  = rd_ptr[PTR_W-1:0];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pending = count;

  // ready_q holds lu_ready low through reset and the edge that releases it.
  assign lu_ready = ready_q && !full;

  // Writes to x0 are acknowledged but never stored.
  assign push = lu_valid && lu_ready && (lu_addr != '0);

  // Arbitration: WB wins unless the FIFO has starved long enough.
  always_comb begin
    force_fifo = (starve_cnt == SC_W'(STARVE_LIMIT)) && !empty;
    wb_win     = wb_en && !force_fifo;
    fifo_win   = !wb_win && !empty;
    wb_stall   = wb_en && force_fifo;
  end

  // FIFO storage; contents are only meaningful inside the occupied window.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_idx] <= lu_addr;
      mem_data[wr_idx] <= lu_data;
    end
  end

  // FIFO pointers, ready flag and starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ready_q    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      ready_q <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_win) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (fifo_win || empty) begin
        starve_cnt <= '0;
      end else if (wb_win && starve_cnt != SC_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Register the arbitration winner onto the regfile write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_en   <= 1'b0;
      reg_write_addr <= '0;
      reg_write_data <= '0;
    end else if (fifo_win) begin
      reg_write_en   <= 1'b1;
      reg_write_addr <= mem_addr[rd_idx];
      reg_write_data <= mem_data[rd_idx];
    end else if (wb_win && wb_addr != '0) begin
      reg_write_en   <= 1'b1;
      reg_write_addr <= wb_addr;
      reg_write_data <= wb_data;
    end else begin
      reg_write_en   <= 1'b0;
      reg_write_addr <= '0;
      reg_write_data <= '0;
    end
  end

  // Youngest pending write wins: the staged write is oldest, then FIFO
  // entries oldest to youngest, each later match overriding earlier ones.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] a);
    logic                  hit;
    logic [DATA_WIDTH-1:0] d;
    logic [PTR_W-1:0]      idx;
    hit = 1'b0;
    d   = '0;
    if (a != '0) begin
      if (reg_write_en && reg_write_addr == a) begin
        hit = 1'b1;
        d   = reg_write_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_idx + PTR_W'(k);
        if (CNT_W'(k) < count && mem_addr[idx] == a) begin
          hit = 1'b1;
          d   = mem_data[idx];
        end
      end
    end
    return {hit, d};
  endfunction

  // Two independent lookup ports for the ID-stage read path.
  always_comb begin
    {q_hit_1, q_data_1} = lookup(q_addr_1);
    {q_hit_2, q_data_2} = lookup(q_addr_2);
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        reg_write_en;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic [4:0]  q_addr_1;
  logic [4:0]  q_addr_2;
  logic        q_hit_1;
  logic        q_hit_2;
  logic [31:0] q_data_1;
  logic [31:0] q_data_2;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .DEPTH(4),
    .STARVE_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .wb_stall(wb_stall),
    .lu_valid(lu_valid),
    .lu_ready(lu_ready),
    .lu_addr(lu_addr),
    .lu_data(lu_data),
    .reg_write_en(reg_write_en),
    .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data),
    .q_addr_1(q_addr_1),
    .q_addr_2(q_addr_2),
    .q_hit_1(q_hit_1),
    .q_hit_2(q_hit_2),
    .q_data_1(q_data_1),
    .q_data_2(q_data_2),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    q_addr_1 = '0; q_addr_2 = '0;

    tick();
    chk("rst_lu_ready", 64'(lu_ready), 64'd0);
    chk("rst_we", 64'(reg_write_en), 64'd0);
    chk("rst_waddr", 64'(reg_write_addr), 64'd0);
    chk("rst_wdata", 64'(reg_write_data), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_hit1", 64'(q_hit_1), 64'd0);
    chk("rst_qdata2", 64'(q_data_2), 64'd0);

    rst = 1'b1;
    #1;
    chk("rel_lu_ready_low", 64'(lu_ready), 64'd0);
    tick();
    chk("rel_lu_ready_high", 64'(lu_ready), 64'd1);
    chk("rel_we", 64'(reg_write_en), 64'd0);

    // Simple WB write with empty FIFO
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    #1;
    chk("wb_stall_idle", 64'(wb_stall), 64'd0);
    tick();
    chk("wb_we", 64'(reg_write_en), 64'd1);
    chk("wb_addr", 64'(reg_write_addr), 64'd5);
    chk("wb_data", 64'(reg_write_data), 64'h1234);
    wb_en = 1'b0;
    q_addr_1 = 5'd5;
    #1;
    chk("fwd_stage_hit", 64'(q_hit_1), 64'd1);
    chk("fwd_stage_data", 64'(q_data_1), 64'h1234);
    q_addr_1 = '0;
    tick();
    chk("wb_done_we", 64'(reg_write_en), 64'd0);

    // Fill FIFO while WB (to x0) holds the port
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hdead;
    for (int i = 1; i <= 4; i++) begin
      lu_valid = 1'b1; lu_addr = 5'(i); lu_data = 32'hA0 + 32'(i);
      tick();
    end
    lu_valid = 1'b0;
    chk("full_lu_ready", 64'(lu_ready), 64'd0);
    chk("full_pending", 64'(pending), 64'd4);
    chk("full_we_x0", 64'(reg_write_en), 64'd0);
    q_addr_1 = 5'd3;
    #1;
    chk("full_hit3", 64'(q_hit_1), 64'd1);
    chk("full_data3", 64'(q_data_1), 64'hA3);
    q_addr_1 = '0;

    // Drain in order; offered push while full is refused
    wb_en = 1'b0;
    lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99;
    tick();
    lu_valid = 1'b0;
    chk("pop1_addr", 64'(reg_write_addr), 64'd1);
    chk("pop1_data", 64'(reg_write_data), 64'hA1);
    chk("pop1_pending", 64'(pending), 64'd3);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("pop_we", 64'(reg_write_en), 64'd1);
      chk("pop_addr", 64'(reg_write_addr), 64'(i));
      chk("pop_data", 64'(reg_write_data), 64'hA0 + 64'(i));
      chk("pop_pending", 64'(pending), 64'(4 - i));
    end
    tick();
    chk("drained_we", 64'(reg_write_en), 64'd0);
    chk("drained_pending", 64'(pending), 64'd0);

    // Starvation: FIFO entry forced after three WB wins
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h77;
    tick();
    lu_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("starve_stall0", 64'(wb_stall), 64'd0);
      tick();
      chk("starve_wb_we", 64'(reg_write_en), 64'd1);
      chk("starve_wb_addr", 64'(reg_write_addr), 64'd10);
    end
    #1;
    chk("starve_stall1", 64'(wb_stall), 64'd1);
    tick();
    chk("forced_addr", 64'(reg_write_addr), 64'd7);
    chk("forced_data", 64'(reg_write_data), 64'h77);
    chk("forced_pending", 64'(pending), 64'd0);
    #1;
    chk("after_force_stall", 64'(wb_stall), 64'd0);
    tick();
    chk("held_wb_addr", 64'(reg_write_addr), 64'd10);
    chk("held_wb_data", 64'(reg_write_data), 64'h100);
    wb_en = 1'b0;
    tick();

    // Youngest-first lookup
    wb_en = 1'b1; wb_addr = 5'd0;
    lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h11;
    tick();
    lu_data = 32'h22;
    tick();
    lu_valid = 1'b0;
    q_addr_1 = 5'd3; q_addr_2 = 5'd0;
    #1;
    chk("young_hit1", 64'(q_hit_1), 64'd1);
    chk("young_data1", 64'(q_data_1), 64'h22);
    chk("x0_hit2", 64'(q_hit_2), 64'd0);
    chk("x0_data2", 64'(q_data_2), 64'd0);
    q_addr_2 = 5'd6;
    #1;
    chk("miss_hit2", 64'(q_hit_2), 64'd0);
    wb_en = 1'b0;
    tick();
    chk("dup_pop1_data", 64'(reg_write_data), 64'h11);
    chk("dup_fwd_fifo", 64'(q_data_1), 64'h22);
    tick();
    chk("dup_pop2_data", 64'(reg_write_data), 64'h22);
    chk("dup_fwd_stage", 64'(q_data_1), 64'h22);
    tick();
    chk("dup_idle_hit", 64'(q_hit_1), 64'd0);
    q_addr_1 = '0; q_addr_2 = '0;

    // x0 pushes are discarded; x0 WB writes never assert enable
    lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h55;
    tick();
    lu_valid = 1'b0;
    chk("x0_push_pending", 64'(pending), 64'd0);
    tick();
    chk("x0_push_we", 64'(reg_write_en), 64'd0);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hff;
    tick();
    chk("x0_wb_we", 64'(reg_write_en), 64'd0);
    chk("x0_wb_addr", 64'(reg_write_addr), 64'd0);

    // Reset mid-operation
    lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'hC1;
    tick();
    lu_addr = 5'd13; lu_data = 32'hC2;
    tick();
    lu_valid = 1'b0;
    wb_addr = 5'd8; wb_data = 32'h88;
    tick();
    chk("mid_we", 64'(reg_write_en), 64'd1);
    chk("mid_pending", 64'(pending), 64'd2);
    q_addr_1 = 5'd12;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 64'(reg_write_en), 64'd0);
    chk("mid_rst_pending", 64'(pending), 64'd0);
    chk("mid_rst_lu_ready", 64'(lu_ready), 64'd0);
    chk("mid_rst_hit", 64'(q_hit_1), 64'd0);
    wb_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("rerel_lu_ready", 64'(lu_ready), 64'd1);
    chk("rerel_we", 64'(reg_write_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
